led_fx_engine: RTL
==================

# led_fx_engine

Parametrised successor to the 8-LED on/off light controller in the audio visualiser path. Sits after the FFT magnitude stage and beat detector and drives NUM_CH LED channels with per-channel PWM brightness instead of on/off levels. Adds peak-hold/decay smoothing, a prescaled effect tick, mode-change hysteresis, and a manual mode override.

## Interface
Parameters:
- NUM_CH, 8: LED/band channel count, ≥4.
- MAG_W, 16: magnitude width per channel.
- PWM_W, 8: duty/PWM counter width.
- TICK_DIV, 256: clk cycles per effect tick, ≥2.
- DECAY_STEP, 4: level decrement per tick.
- MODE_HOLD, 64: minimum ticks between auto mode changes.
- STROBE_LEN, 4: ticks the strobe stays lit after a beat.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  block enable.
- fft_mag_flat  in  NUM_CH*MAG_W  channel i at [i*MAG_W +: MAG_W].
- mag_valid  in  1  one-cycle strobe, new frame on fft_mag_flat.
- beat_pulse  in  1  one-cycle beat strobe.
- bpm_value  in  8  current tempo.
- mode_auto  in  1  1 = auto selection, 0 = manual.
- mode_sel  in  3  manual mode.
- led_out  out  NUM_CH  PWM outputs.
- cur_mode  out  3  active mode.

## Operation
- Reset: led_out=0, cur_mode=0, levels, duties, phase, prescaler, pwm_cnt, hold_cnt, strobe_cnt all 0.
- Tick: prescaler counts 0..TICK_DIV-1 and asserts tick for one cycle at wrap. phase (PWM_W) increments on each tick and wraps.
- Level i: sample = mag_i[MAG_W-1 -: PWM_W]. On tick, level saturates down by DECAY_STEP toward 0. On mag_valid, level = max(level, sample). When both occur in the same cycle, level = max(decayed level, sample).
- Modes (duty per channel):
  - 0 SPECTRUM: level_i.
  - 1 PULSE: triangle(phase) on all channels, where triangle = phase<2^(PWM_W-1) ? 2*phase : 2*(2^PWM_W-1-phase).
  - 2 STROBE: all full-scale while strobe_cnt≠0, else 0. beat_pulse loads STROBE_LEN; each tick decrements it, saturating at 0. A beat arriving on a tick reloads.
  - 3 STAR: full-scale only on channel phase[PWM_W-1 -: log2(NUM_CH)] mod NUM_CH.
  - 4 WAVE: triangle(phase + i*(2^PWM_W/NUM_CH)) mod 2^PWM_W.
  - 5–7: duty 0.
- Auto selection, evaluated on mag_valid. low = level_0+level_1, high = level_{NUM_CH-2}+level_{NUM_CH-1}, both PWM_W+1 bits. Candidate is:
  - STROBE if a beat occurred since the previous mag_valid and bpm_value>100;
  - else PULSE if low>high;
  - else STAR if high>low;
  - else SPECTRUM.
- Candidate commits only if it differs from cur_mode and hold_cnt==MODE_HOLD. hold_cnt counts ticks and saturates at MODE_HOLD; it clears on each commit.
- Manual: cur_mode=mode_sel on the next cycle; hold_cnt held at 0. On the switch back to auto, hold must be re-earned before the first change.
- PWM: pwm_cnt free-runs. led_out[i] = duty_i > pwm_cnt. Duty 0 is always off; duty 2^PWM_W-1 is off exactly 1 cycle per period.
- enable=0: led_out forced 0 next cycle. Levels, phase, prescaler, pwm_cnt, hold_cnt, strobe_cnt and cur_mode all freeze. Inputs are ignored.

## Timing
- mag_valid at cycle t: level at t+1, duty at t+2, led_out reflects it from t+3 at PWM comparison.
- Auto mode commit: cur_mode updates at t+1 after the mag_valid; the duty stage uses the new mode from t+2.
- Manual mode_sel change at t: cur_mode at t+1.
- Reset asserted mid-frame clears all state asynchronously. The first tick arrives TICK_DIV cycles after release.
- All outputs are registered.

## Configuration
- LED_FX_GAMMA_EN defined: duty stage outputs (d*d)>>PWM_W (full-scale maps to 2^PWM_W-2). Latency is unchanged.
- Not defined: duty is linear.

## Test plan
- Reset, enable=1, mode_auto=0, mode_sel=0, ch0 mag=16'hFF00, mag_valid once -> level_0=0xFF. led_out[0] high 255 of every 256 cycles from t+3; after 1 tick level_0=0xFB.
- Manual mode 2, beat_pulse at t -> all led_out at full duty for 4 ticks (1024 cycles), then 0. A second beat mid-strobe reloads to 4.
- Auto, frames with ch0/1=16'hC000 and ch6/7=0 every 100 cycles -> cur_mode=1 only after 64 ticks. A high-rich frame at tick 10 after the change does not switch.
- Auto, beat then mag_valid with bpm_value=120 -> STROBE after hold. Same with bpm_value=100 -> no STROBE.
- enable dropped for 500 cycles mid-PULSE -> led_out=0, phase unchanged. Resume continues from the same phase.
- With LED_FX_GAMMA_EN: level 0x80 -> duty 0x40. Without: duty 0x80.

Source files
------------

// File: rtl/led_fx_engine.sv
// led_fx_engine: audio-visualiser LED effect engine.
// Drives NUM_CH PWM LED channels from FFT band magnitudes and beat strobes
// with peak-hold/decay levels, a prescaled effect tick, auto mode selection
// with hysteresis and a manual mode override.
// Optional feature macro: LED_FX_GAMMA_EN (square-law duty shaping).
module led_fx_engine #(
  parameter int NUM_CH     = 8,
  parameter int MAG_W      = 16,
  parameter int PWM_W      = 8,
  parameter int TICK_DIV   = 256,
  parameter int DECAY_STEP = 4,
  parameter int MODE_HOLD  = 64,
  parameter int STROBE_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_CH*MAG_W-1:0] fft_mag_flat,
  input  logic                    mag_valid,
  input  logic                    beat_pulse,
  input  logic [7:0]              bpm_value,
  input  logic                    mode_auto,
  input  logic [2:0]              mode_sel,
  output logic [NUM_CH-1:0]       led_out,
  output logic [2:0]              cur_mode
);

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int HOLD_W = $clog2(MODE_HOLD + 1);
  localparam int STR_W  = $clog2(STROBE_LEN + 1);

  localparam logic [2:0] MODE_SPECTRUM = 3'd0;
  localparam logic [2:0] MODE_PULSE    = 3'd1;
  localparam logic [2:0] MODE_STROBE   = 3'd2;
  localparam logic [2:0] MODE_STAR     = 3'd3;
  localparam logic [2:0] MODE_WAVE     = 3'd4;

  localparam logic [PWM_W-1:0]  FULL        = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0]  ZERO        = {PWM_W{1'b0}};
  localparam logic [PWM_W-1:0]  DECAY       = PWM_W'(DECAY_STEP);
  localparam logic [PWM_W-1:0]  WAVE_STEP   = PWM_W'((2 ** PWM_W) / NUM_CH);
  localparam logic [CNT_W-1:0]  PRESC_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(MODE_HOLD);
  localparam logic [STR_W-1:0]  STROBE_LOAD = STR_W'(STROBE_LEN);
  localparam logic [7:0]        BPM_FAST    = 8'd100;

  // Rising-then-falling ramp over one phase period, peak 2^PWM_W-2.
  function automatic logic [PWM_W-1:0] tri_wave(input logic [PWM_W-1:0] p);
    logic [PWM_W-1:0] r;
    if (!p[PWM_W-1]) r = {p[PWM_W-2:0], 1'b0};
    else             r = {~p[PWM_W-2:0], 1'b0};
    return r;
  endfunction

  // Final duty shaping: square law when gamma is built in, identity otherwise.
  function automatic logic [PWM_W-1:0] shape_duty(input logic [PWM_W-1:0] d);
`ifdef LED_FX_GAMMA_EN
    logic [2*PWM_W-1:0] sq;
    sq = {{PWM_W{1'b0}}, d} * {{PWM_W{1'b0}}, d};
    return sq[2*PWM_W-1:PWM_W];
`else
    return d;
`endif
  endfunction

  logic [CNT_W-1:0]  r_presc;
  logic [PWM_W-1:0]  r_phase;
  logic [PWM_W-1:0]  r_pwm_cnt;
  logic [PWM_W-1:0]  r_level [NUM_CH];
  logic [PWM_W-1:0]  r_duty  [NUM_CH];
  logic [HOLD_W-1:0] r_hold;
  logic [STR_W-1:0]  r_strobe;
  logic              r_beat_seen;
  logic [2:0]        r_mode;
  logic [NUM_CH-1:0] r_led;

  logic              w_tick;
  logic [PWM_W-1:0]  w_level_nxt [NUM_CH];
  logic [PWM_W-1:0]  w_duty_nxt  [NUM_CH];
  logic [PWM_W:0]    w_low;
  logic [PWM_W:0]    w_high;
  logic [2:0]        w_cand;
  logic              w_commit;
  logic              w_unused_mag;

  // Only the top PWM_W bits of each magnitude feed the level stage.
  assign w_unused_mag = ^fft_mag_flat;

  assign w_tick   = enable && (r_presc == PRESC_MAX);
  assign w_low    = {1'b0, r_level[0]} + {1'b0, r_level[1]};
  assign w_high   = {1'b0, r_level[NUM_CH-2]} + {1'b0, r_level[NUM_CH-1]};
  assign w_commit = enable && mode_auto && mag_valid &&
                    (w_cand != r_mode) && (r_hold == HOLD_MAX);
  assign led_out  = r_led;
  assign cur_mode = r_mode;

  // Auto-mode candidate: fast beat wins, else whichever band end is louder.
  always_comb begin
    w_cand = MODE_SPECTRUM;
    if ((r_beat_seen || beat_pulse) && (bpm_value > BPM_FAST)) w_cand = MODE_STROBE;
    else if (w_low > w_high)                                    w_cand = MODE_PULSE;
    else if (w_high > w_low)                                    w_cand = MODE_STAR;
    else                                                        w_cand = MODE_SPECTRUM;
  end

  // Next level per channel: decay on tick, then peak-hold against the new sample.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      logic [PWM_W-1:0] smp;
      logic [PWM_W-1:0] dec;
      smp = fft_mag_flat[i*MAG_W + MAG_W - 1 -: PWM_W];
      if (w_tick) dec = (r_level[i] > DECAY) ? (r_level[i] - DECAY) : ZERO;
      else        dec = r_level[i];
      if (mag_valid && (smp > dec)) w_level_nxt[i] = smp;
      else                          w_level_nxt[i] = dec;
    end
  end

  // Per-channel duty for the active mode.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      logic [PWM_W-1:0] d;
      logic [PWM_W-1:0] ph;
      int               star_ch;
      star_ch = int'(r_phase[PWM_W-1 -: IDX_W]) % NUM_CH;
      ph      = r_phase + PWM_W'(i) * WAVE_STEP;
      case (r_mode)
        MODE_SPECTRUM: d = r_level[i];
        MODE_PULSE:    d = tri_wave(r_phase);
        MODE_STROBE:   d = (r_strobe != {STR_W{1'b0}}) ? FULL : ZERO;
        MODE_STAR:     d = (i == star_ch) ? FULL : ZERO;
        MODE_WAVE:     d = tri_wave(ph);
        default:       d = ZERO;
      endcase
      w_duty_nxt[i] = shape_duty(d);
    end
  end

  // Effect-tick prescaler, effect phase and free-running PWM counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= {CNT_W{1'b0}};
      r_phase   <= ZERO;
      r_pwm_cnt <= ZERO;
    end else if (enable) begin
      r_presc   <= w_tick ? {CNT_W{1'b0}} : r_presc + CNT_W'(1);
      r_phase   <= w_tick ? r_phase + PWM_W'(1) : r_phase;
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
    end
  end

  // Peak-hold levels and the duty pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_level[i] <= ZERO;
        r_duty[i]  <= ZERO;
      end
    end else if (enable) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_level[i] <= w_level_nxt[i];
        r_duty[i]  <= w_duty_nxt[i];
      end
    end
  end

  // Beat bookkeeping: strobe countdown and beat-since-last-frame flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strobe    <= {STR_W{1'b0}};
      r_beat_seen <= 1'b0;
    end else if (enable) begin
      if (beat_pulse)                              r_strobe <= STROBE_LOAD;
      else if (w_tick && (r_strobe != {STR_W{1'b0}})) r_strobe <= r_strobe - STR_W'(1);
      if (mag_valid)       r_beat_seen <= 1'b0;
      else if (beat_pulse) r_beat_seen <= 1'b1;
    end
  end

  // Mode register and the hysteresis counter that gates auto changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_SPECTRUM;
      r_hold <= {HOLD_W{1'b0}};
    end else if (enable) begin
      if (!mode_auto)    r_mode <= mode_sel;
      else if (w_commit) r_mode <= w_cand;
      if (!mode_auto || w_commit)          r_hold <= {HOLD_W{1'b0}};
      else if (w_tick && (r_hold != HOLD_MAX)) r_hold <= r_hold + HOLD_W'(1);
    end
  end

  // PWM comparison; outputs go dark while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_led[i] <= enable && (r_duty[i] > r_pwm_cnt);
      end
    end
  end

endmodule
